// File: rtl/spi_ram_responder.sv
// SPI mode-0 responder emulating a 23LC-style serial SRAM (READ 0x03 / WRITE 0x02).
// All SPI pins are oversampled by clk; spi_clk edges are detected after a
// 2-FF synchronizer and turned into byte accesses on a synchronous memory port.
module spi_ram_responder #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk,
    input  logic              spi_ce_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    // Bit positions of the synchronized pin bus and their idle levels
    localparam int SYNC_N = 3;
    localparam int IDX_SCLK = 0;
    localparam int IDX_CE = 1;
    localparam int IDX_MOSI = 2;
    localparam logic [SYNC_N-1:0] SYNC_IDLE = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_WRITE,
        ST_IGNORE
    } state_t;

    logic [SYNC_N-1:0] pin_bus;
    logic [SYNC_N-1:0] sync_bus;

    assign pin_bus = {spi_mosi, spi_ce_n, spi_clk};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_N; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            // Two-stage synchronizer, reset to the pin's idle level
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    meta_reg <= SYNC_IDLE[gi];
                    sync_reg <= SYNC_IDLE[gi];
                end else begin
                    meta_reg <= pin_bus[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_bus[gi] = sync_reg;
        end
    endgenerate

    logic sclk_s;
    logic ce_s;
    logic mosi_s;

    assign sclk_s = sync_bus[IDX_SCLK];
    assign ce_s   = sync_bus[IDX_CE];
    assign mosi_s = sync_bus[IDX_MOSI];

    logic sclk_prev_reg;
    logic sclk_rise_reg;
    logic sclk_fall_reg;
    logic ce_prev_reg;

    // Registered edge flags on the synchronized SPI clock and chip enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_prev_reg <= 1'b0;
            sclk_rise_reg <= 1'b0;
            sclk_fall_reg <= 1'b0;
            ce_prev_reg   <= 1'b1;
        end else begin
            sclk_prev_reg <= sclk_s;
            sclk_rise_reg <= sclk_s & ~sclk_prev_reg;
            sclk_fall_reg <= ~sclk_s & sclk_prev_reg;
            ce_prev_reg   <= ce_s;
        end
    end

    state_t            state_reg;
    logic [4:0]        bit_cnt_reg;
    logic [7:0]        shift_reg;
    logic [ADDR_W-1:0] addr_sr_reg;
    logic              is_read_reg;
    logic [7:0]        tx_reg;
    logic              load_pending_reg;
    logic              miso_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        wdata_reg;
    logic              we_reg;
    logic              re_reg;

    // Byte being completed by the current rising edge and the full address
    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] addr_next;

    assign rx_byte   = {shift_reg[6:0], mosi_s};
    assign addr_next = {addr_sr_reg[ADDR_W-2:0], mosi_s};

    // Protocol state machine with registered memory strobes and MISO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            addr_sr_reg      <= '0;
            is_read_reg      <= 1'b0;
            tx_reg           <= '0;
            load_pending_reg <= 1'b0;
            miso_reg         <= 1'b0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            we_reg           <= 1'b0;
            re_reg           <= 1'b0;
        end else begin
            we_reg           <= 1'b0;
            re_reg           <= 1'b0;
            // Read data arrives one clk after the strobe cycle
            load_pending_reg <= re_reg;
            if (load_pending_reg) begin
                tx_reg <= mem_rdata;
            end
            // Post-increment after each write strobe
            if (we_reg) begin
                addr_reg <= addr_reg + ADDR_W'(1);
            end

            if (ce_s) begin
                state_reg   <= ST_IDLE;
                bit_cnt_reg <= '0;
                miso_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        miso_reg <= 1'b0;
                        if (ce_prev_reg) begin
                            state_reg   <= ST_CMD;
                            bit_cnt_reg <= '0;
                        end
                    end
                    ST_CMD: begin
                        miso_reg <= 1'b0;
                        if (sclk_rise_reg) begin
                            shift_reg   <= rx_byte;
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            if (bit_cnt_reg == 5'd7) begin
                                bit_cnt_reg <= '0;
                                case (rx_byte)
                                    8'h03: begin
                                        is_read_reg <= 1'b1;
                                        state_reg   <= ST_ADDR;
                                    end
                                    8'h02: begin
                                        is_read_reg <= 1'b0;
                                        state_reg   <= ST_ADDR;
                                    end
                                    default: state_reg <= ST_IGNORE;
                                endcase
                            end
                        end
                    end
                    ST_ADDR: begin
                        miso_reg <= 1'b0;
                        if (sclk_rise_reg) begin
                            addr_sr_reg <= addr_next;
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            if (bit_cnt_reg == 5'd23) begin
                                bit_cnt_reg <= '0;
                                addr_reg    <= addr_next;
                                if (is_read_reg) begin
                                    re_reg    <= 1'b1;
                                    state_reg <= ST_READ;
                                end else begin
                                    state_reg <= ST_WRITE;
                                end
                            end
                        end
                    end
                    ST_READ: begin
                        if (sclk_fall_reg) begin
                            miso_reg <= tx_reg[7];
                            tx_reg   <= {tx_reg[6:0], 1'b0};
                        end
                        if (sclk_rise_reg) begin
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            if (bit_cnt_reg == 5'd7) begin
                                // Byte done: advance and prefetch the next one
                                bit_cnt_reg <= '0;
                                addr_reg    <= addr_reg + ADDR_W'(1);
                                re_reg      <= 1'b1;
                            end
                        end
                    end
                    ST_WRITE: begin
                        miso_reg <= 1'b0;
                        if (sclk_rise_reg) begin
                            shift_reg   <= rx_byte;
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            if (bit_cnt_reg == 5'd7) begin
                                bit_cnt_reg <= '0;
                                wdata_reg   <= rx_byte;
                                we_reg      <= 1'b1;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        miso_reg <= 1'b0;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        miso_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign spi_miso  = miso_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_we    = we_reg;
    assign mem_re    = re_reg;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: SPI initiator tasks, byte memory
// model on the memory port, and strobe logs inspected after each transaction.
module tb_spi_ram_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_ce_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_ram_responder #(.ADDR_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_clk   (spi_clk),
        .spi_ce_n  (spi_ce_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    // Memory model: registered read, write on strobe, bench-side preload port
    logic [7:0]  mem [0:65535];
    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
        if (pre_en) mem[pre_addr] = pre_data;
    end

    // Strobe and MISO activity logs
    logic [15:0] we_a_q[$];
    logic [7:0]  we_d_q[$];
    logic [15:0] re_a_q[$];
    int          miso_hi_cnt = 0;
    int          both_cnt = 0;

    always @(posedge clk) begin
        if (mem_we) begin
            we_a_q.push_back(mem_addr);
            we_d_q.push_back(mem_wdata);
        end
        if (mem_re) re_a_q.push_back(mem_addr);
        if (spi_miso === 1'b1) miso_hi_cnt++;
        if (mem_we && mem_re) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    // Shift out the top n bits of b; r collects MISO sampled just before each rise
    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
        r = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            wait_clk(HALF);
            r = {r[6:0], spi_miso};
            spi_clk = 1'b1;
            wait_clk(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        spi_bits(b, 8, r);
    endtask

    task automatic cs_begin();
        @(negedge clk);
        spi_ce_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_end();
        wait_clk(HALF);
        spi_ce_n = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(HALF + 4);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_miso"}, {31'd0, spi_miso}, 32'h0);
        check({tag, "_we"}, {31'd0, mem_we}, 32'h0);
        check({tag, "_re"}, {31'd0, mem_re}, 32'h0);
        check({tag, "_wdata"}, {24'd0, mem_wdata}, 32'h0);
        check({tag, "_addr"}, {16'd0, mem_addr}, 32'h0);
    endtask

    initial begin
        logic [7:0] r0, r1, r2, r3;
        int wb, rb, mb;

        // Reset state
        rst_n = 1'b0;
        wait_clk(5);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        wait_clk(5);

        // Write burst: 0xA5 @0x0010, 0x3C @0x0011
        wb = we_a_q.size(); rb = re_a_q.size(); mb = miso_hi_cnt;
        cs_begin();
        spi_byte(8'h02, r0); spi_byte(8'h00, r1); spi_byte(8'h00, r2); spi_byte(8'h10, r3);
        spi_byte(8'hA5, r0); spi_byte(8'h3C, r1);
        cs_end();
        check("wr_we_count", we_a_q.size() - wb, 2);
        check("wr_addr0", {16'd0, we_a_q[wb]}, 32'h0010);
        check("wr_data0", {24'd0, we_d_q[wb]}, 32'hA5);
        check("wr_addr1", {16'd0, we_a_q[wb+1]}, 32'h0011);
        check("wr_data1", {24'd0, we_d_q[wb+1]}, 32'h3C);
        check("wr_re_count", re_a_q.size() - rb, 0);
        check("wr_miso_quiet", miso_hi_cnt - mb, 0);
        $display("TXN write burst @0010 A5 3C done");

        // Read burst from 0x0020
        preload(16'h0020, 8'h5A);
        preload(16'h0021, 8'hC3);
        wb = we_a_q.size(); rb = re_a_q.size();
        cs_begin();
        spi_byte(8'h03, r0); spi_byte(8'h00, r1); spi_byte(8'h00, r2); spi_byte(8'h20, r3);
        spi_byte(8'h00, r0); spi_byte(8'h00, r1);
        cs_end();
        check("rd_byte0", {24'd0, r0}, 32'h5A);
        check("rd_byte1", {24'd0, r1}, 32'hC3);
        check("rd_re_count", re_a_q.size() - rb, 3);
        check("rd_re_addr0", {16'd0, re_a_q[rb]}, 32'h0020);
        check("rd_re_addr1", {16'd0, re_a_q[rb+1]}, 32'h0021);
        check("rd_re_addr2", {16'd0, re_a_q[rb+2]}, 32'h0022);
        check("rd_we_count", we_a_q.size() - wb, 0);
        $display("TXN read burst @0020 got %h %h", r0, r1);

        // Address wrap from 0x00FFFF
        wb = we_a_q.size();
        cs_begin();
        spi_byte(8'h02, r0); spi_byte(8'h00, r1); spi_byte(8'hFF, r2); spi_byte(8'hFF, r3);
        spi_byte(8'h11, r0); spi_byte(8'h22, r1);
        cs_end();
        check("wrap_we_count", we_a_q.size() - wb, 2);
        check("wrap_addr0", {16'd0, we_a_q[wb]}, 32'hFFFF);
        check("wrap_data0", {24'd0, we_d_q[wb]}, 32'h11);
        check("wrap_addr1", {16'd0, we_a_q[wb+1]}, 32'h0000);
        check("wrap_data1", {24'd0, we_d_q[wb+1]}, 32'h22);
        $display("TXN wrap write @FFFF 11 22 done");

        // Unknown command 0x9F followed by 24 clocks
        wb = we_a_q.size(); rb = re_a_q.size(); mb = miso_hi_cnt;
        cs_begin();
        spi_byte(8'h9F, r0); spi_byte(8'hFF, r1); spi_byte(8'hFF, r2); spi_byte(8'hFF, r3);
        cs_end();
        check("unk_we_count", we_a_q.size() - wb, 0);
        check("unk_re_count", re_a_q.size() - rb, 0);
        check("unk_miso_quiet", miso_hi_cnt - mb, 0);
        cs_begin();
        spi_byte(8'h03, r0); spi_byte(8'h00, r1); spi_byte(8'h00, r2); spi_byte(8'h10, r3);
        spi_byte(8'h00, r0);
        cs_end();
        check("unk_next_read", {24'd0, r0}, 32'hA5);
        $display("TXN unknown cmd 9F ignored, follow-up read got %h", r0);

        // Abort: 5 data bits of a write then CE high
        preload(16'h0040, 8'h96);
        wb = we_a_q.size();
        cs_begin();
        spi_byte(8'h02, r0); spi_byte(8'h00, r1); spi_byte(8'h00, r2); spi_byte(8'h40, r3);
        spi_bits(8'hFF, 5, r0);
        cs_end();
        check("abort_we_count", we_a_q.size() - wb, 0);
        rb = re_a_q.size();
        cs_begin();
        spi_byte(8'h03, r0); spi_byte(8'h00, r1); spi_byte(8'h00, r2); spi_byte(8'h40, r3);
        spi_byte(8'h00, r0);
        cs_end();
        check("abort_read_data", {24'd0, r0}, 32'h96);
        check("abort_read_addr", {16'd0, re_a_q[rb]}, 32'h0040);
        $display("TXN abort write @0040, read back %h", r0);

        // Reset in the middle of a read data byte (0x5A @0x0020)
        cs_begin();
        spi_byte(8'h03, r0); spi_byte(8'h00, r1); spi_byte(8'h00, r2); spi_byte(8'h20, r3);
        spi_bits(8'h00, 3, r0);
        wait_clk(6);
        check("midrd_miso_bit4", {31'd0, spi_miso}, 32'h1);
        check("midrd_addr", {16'd0, mem_addr}, 32'h0020);
        rst_n = 1'b0;
        wait_clk(1);
        check_idle_outputs("midrd_reset");
        wait_clk(3);
        spi_ce_n = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        wb = we_a_q.size();
        cs_begin();
        spi_byte(8'h02, r0); spi_byte(8'h00, r1); spi_byte(8'h00, r2); spi_byte(8'h01, r3);
        spi_byte(8'h77, r0);
        cs_end();
        check("post_rst_we_count", we_a_q.size() - wb, 1);
        check("post_rst_addr", {16'd0, we_a_q[wb]}, 32'h0001);
        check("post_rst_data", {24'd0, we_d_q[wb]}, 32'h77);
        $display("TXN reset mid-read, then write @0001 77 done");

        check("no_re_we_overlap", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
